// File: rtl/n25q_stream_reader_if.sv
// n25q_stream_reader_if: N25Q di_* terminal bus plus the outgoing word stream
interface n25q_stream_reader_if;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_reg_datai;
    logic [31:0] di_len;
    logic        di_write_mode;
    logic        di_write;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_write_rdy;
    logic        di_read_rdy;
    logic [31:0] di_reg_datao;
    modport master (
        output out_data, out_bytes, out_valid, out_last,
        output di_term_addr, di_reg_addr, di_reg_datai, di_len,
        output di_write_mode, di_write, di_read_mode, di_read_req,
        input  out_ready, di_write_rdy, di_read_rdy, di_reg_datao
    );
    modport slave (
        input  out_data, out_bytes, out_valid, out_last,
        input  di_term_addr, di_reg_addr, di_reg_datai, di_len,
        input  di_write_mode, di_write, di_read_mode, di_read_req,
        output out_ready, di_write_rdy, di_read_rdy, di_reg_datao
    );
endinterface

// File: rtl/n25q_stream_reader.sv
// n25q_stream_reader: autonomous N25Q read sequencer streaming flash bytes as 32-bit words
module n25q_stream_reader #(
    parameter logic [15:0] CTRL_TERM = 16'h0000,
    parameter logic [15:0] DATA_TERM = 16'h0001,
    parameter logic [31:0] CSB_REG   = 32'd0,
    parameter logic [7:0]  READ_CMD  = 8'h03
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [23:0] flash_addr_i,
    input  logic [23:0] byte_len_i,
    output logic        busy_o,
    output logic        done_o,
    n25q_stream_reader_if.master bus
);
    typedef enum logic [3:0] {IDLE, CS_LO, CMD, CMD_WAIT, GAP, RD, RD_WAIT, OUT, CS_HI, DONE} state_t;
    state_t      state_q, state_d;
    logic [23:0] addr_q, len_q, remain_q, remain_d;
    logic        abort_q, first_q, last_q, stop;
    logic [31:0] data_q, mask;
    logic [2:0]  bytes_q, take;
    assign take     = (remain_q >= 24'd4) ? 3'd4 : remain_q[2:0];
    assign mask     = take == 3'd1 ? 32'h0000_00FF : take == 3'd2 ? 32'h0000_FFFF :
                      take == 3'd3 ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
    assign remain_d = remain_q - {21'd0, bytes_q};
    assign stop     = abort_q | abort_i;
    assign bus.out_data  = data_q;
    assign bus.out_bytes = bytes_q;
    assign bus.out_last  = last_q;
    // state register, sticky abort, and the captured word/remaining-byte datapath
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= IDLE;
            first_q  <= 1'b0;
            abort_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            remain_q <= '0;
            data_q   <= '0;
            bytes_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= state_d != state_q;
            abort_q <= (state_q == IDLE || state_q == CS_HI) ? 1'b0 : stop;
            if (state_q == IDLE && start_i) begin
                addr_q   <= flash_addr_i;
                len_q    <= byte_len_i;
                remain_q <= byte_len_i;
            end
            if (state_q == RD_WAIT && !first_q && bus.di_read_rdy) begin
                data_q  <= bus.di_reg_datao & mask;
                bytes_q <= take;
                last_q  <= (remain_q <= 24'd4) | stop;
            end
            if (state_q == OUT && bus.out_ready)
                remain_q <= remain_d;
        end
    end
    // next state and the di_*/stream outputs decoded from the current state
    always_comb begin
        state_d           = state_q;
        bus.di_term_addr  = '0;
        bus.di_reg_addr   = '0;
        bus.di_reg_datai  = '0;
        bus.di_len        = '0;
        bus.di_write_mode = 1'b0;
        bus.di_write      = 1'b0;
        bus.di_read_mode  = 1'b0;
        bus.di_read_req   = 1'b0;
        bus.out_valid     = 1'b0;
        case (state_q)
            IDLE: if (start_i) state_d = (byte_len_i == 24'd0) ? DONE : CS_LO;
            CS_LO: begin
                bus.di_term_addr  = CTRL_TERM;
                bus.di_reg_addr   = CSB_REG;
                bus.di_write_mode = 1'b1;
                bus.di_write      = 1'b1;
                state_d           = CMD;
            end
            CMD, CMD_WAIT: begin
                bus.di_term_addr  = DATA_TERM;
                bus.di_reg_datai  = {addr_q[7:0], addr_q[15:8], addr_q[23:16], READ_CMD};
                bus.di_len        = 32'd4;
                bus.di_write_mode = 1'b1;
                bus.di_write      = state_q == CMD;
                state_d           = state_q == CMD ? CMD_WAIT :
                                    (!first_q && bus.di_write_rdy) ? GAP : CMD_WAIT;
            end
            GAP: state_d = RD;
            RD, RD_WAIT, OUT: begin
                bus.di_term_addr = DATA_TERM;
                bus.di_len       = {8'd0, len_q};
                bus.di_read_mode = 1'b1;
                bus.di_read_req  = state_q == RD;
                bus.out_valid    = state_q == OUT;
                state_d          = state_q == RD ? RD_WAIT :
                                   state_q == RD_WAIT ? ((!first_q && bus.di_read_rdy) ? OUT : RD_WAIT) :
                                   !bus.out_ready ? OUT : (remain_d == 24'd0 || stop) ? CS_HI : RD;
            end
            CS_HI: begin
                bus.di_term_addr  = CTRL_TERM;
                bus.di_reg_addr   = CSB_REG;
                bus.di_reg_datai  = 32'd1;
                bus.di_write_mode = 1'b1;
                bus.di_write      = 1'b1;
                state_d           = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
endmodule

// File: tb/tb_n25q_stream_reader.sv
// tb_n25q_stream_reader: directed checks of the reader against a small N25Q controller/flash model
module tb_n25q_stream_reader;
    logic        ifclk = 1'b0;
    logic        resetb = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] flash_addr = '0;
    logic [23:0] byte_len = '0;
    logic        busy, done;
    int          vectors = 0;
    int          errs = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    logic [31:0] last_csb = 32'hFFFF_FFFF;
    logic [31:0] last_rdlen = '0;
    n25q_stream_reader_if bus ();
    n25q_stream_reader dut (
        .ifclk(ifclk), .resetb(resetb), .start_i(start), .abort_i(abort),
        .flash_addr_i(flash_addr), .byte_len_i(byte_len),
        .busy_o(busy), .done_o(done), .bus(bus)
    );
    always #5 ifclk = ~ifclk;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return a[7:0] + 8'hA0;
    endfunction

    // controller + flash model: acks DATA writes, answers reads 3 cycles after the request
    initial begin
        int wdly, rdly;
        logic [23:0] ptr;
        wdly = 0; rdly = 0; ptr = '0;
        bus.out_ready = 1'b0;
        bus.di_write_rdy = 1'b0;
        bus.di_read_rdy = 1'b0;
        bus.di_reg_datao = '0;
        forever begin
            @(negedge ifclk);
            bus.di_write_rdy = 1'b0;
            bus.di_read_rdy = 1'b0;
            if (!resetb) begin
                wdly = 0;
                rdly = 0;
            end else begin
                if (wdly == 1) bus.di_write_rdy = 1'b1;
                if (wdly > 0) wdly--;
                if (rdly == 1) begin
                    bus.di_read_rdy = 1'b1;
                    bus.di_reg_datao = {fbyte(ptr + 24'd3), fbyte(ptr + 24'd2), fbyte(ptr + 24'd1), fbyte(ptr)};
                    ptr = ptr + 24'd4;
                end
                if (rdly > 0) rdly--;
                if (bus.di_write) begin
                    n_wr++;
                    if (bus.di_term_addr == 16'h0000) last_csb = bus.di_reg_datai;
                    else begin
                        ptr = {bus.di_reg_datai[15:8], bus.di_reg_datai[23:16], bus.di_reg_datai[31:24]};
                        wdly = 3;
                    end
                end
                if (bus.di_read_req) begin
                    n_rd++;
                    last_rdlen = bus.di_len;
                    rdly = 3;
                end
            end
        end
    end

    task automatic start_xfer(input logic [23:0] a, input logic [23:0] l);
        flash_addr = a;
        byte_len = l;
        start = 1'b1;
        @(negedge ifclk);
        start = 1'b0;
    endtask

    task automatic get_word(input int stall, output logic [31:0] d, output logic [2:0] b,
                            output logic l, output bit ok, output bit stable, output bit rd_moved);
        int t, n0;
        t = 0; ok = 1'b0; stable = 1'b1; rd_moved = 1'b0;
        d = '0; b = '0; l = 1'b0;
        while (!bus.out_valid && t < 200) begin
            @(negedge ifclk);
            t++;
        end
        if (bus.out_valid) begin
            ok = 1'b1;
            d = bus.out_data;
            b = bus.out_bytes;
            l = bus.out_last;
            n0 = n_rd;
            repeat (stall) begin
                @(negedge ifclk);
                if (!bus.out_valid || bus.out_data !== d || bus.out_bytes !== b || bus.out_last !== l)
                    stable = 1'b0;
            end
            rd_moved = n_rd != n0;
            bus.out_ready = 1'b1;
            @(negedge ifclk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge ifclk);
        end
        @(negedge ifclk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge ifclk);
        vectors++;
        if ({busy, done, bus.out_valid, bus.di_write, bus.di_read_req, bus.di_write_mode, bus.di_read_mode} !== 7'd0) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 0000000", {busy, done, bus.out_valid, bus.di_write, bus.di_read_req, bus.di_write_mode, bus.di_read_mode});
        end
        vectors++;
        if (bus.out_data !== 32'd0 || bus.out_bytes !== 3'd0 || bus.out_last !== 1'b0 || bus.di_term_addr !== 16'd0 || bus.di_len !== 32'd0) begin
            errs++;
            $display("FAIL reset_data: out_data=%h bytes=%0d last=%b term=%h len=%h want all 0", bus.out_data, bus.out_bytes, bus.out_last, bus.di_term_addr, bus.di_len);
        end
        resetb = 1'b1;
        @(negedge ifclk);
        vectors++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_len8;
        logic [31:0] d; logic [2:0] b; logic l; bit ok, st, mv;
        int w0, r0;
        w0 = n_wr; r0 = n_rd;
        start_xfer(24'h123456, 24'd8);
        vectors++;
        if ({busy, bus.di_write, bus.di_write_mode} !== 3'b111 || bus.di_term_addr !== 16'h0000 || bus.di_reg_datai !== 32'd0) begin
            errs++;
            $display("FAIL len8_cs_lo: busy/wr/wm=%b term=%h datai=%h want 111 0000 00000000", {busy, bus.di_write, bus.di_write_mode}, bus.di_term_addr, bus.di_reg_datai);
        end
        @(negedge ifclk);
        vectors++;
        if (bus.di_write !== 1'b1 || bus.di_term_addr !== 16'h0001 || bus.di_reg_datai !== 32'h56341203 || bus.di_len !== 32'd4) begin
            errs++;
            $display("FAIL len8_cmd: wr=%b term=%h datai=%h len=%h want 1 0001 56341203 4", bus.di_write, bus.di_term_addr, bus.di_reg_datai, bus.di_len);
        end
        get_word(0, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'hF9F8F7F6 || b !== 3'd4 || l !== 1'b0) begin
            errs++;
            $display("FAIL len8_w1: ok=%b data=%h bytes=%0d last=%b want F9F8F7F6 4 0", ok, d, b, l);
        end
        vectors++;
        if (last_rdlen !== 32'd8) begin
            errs++;
            $display("FAIL len8_rdlen: got %h want 8", last_rdlen);
        end
        get_word(0, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'hFDFCFBFA || b !== 3'd4 || l !== 1'b1) begin
            errs++;
            $display("FAIL len8_w2: ok=%b data=%h bytes=%0d last=%b want FDFCFBFA 4 1", ok, d, b, l);
        end
        wait_done(ok);
        vectors++;
        if (!ok || last_csb !== 32'd1 || n_wr - w0 != 3 || n_rd - r0 != 2) begin
            errs++;
            $display("FAIL len8_end: done=%b csb=%h writes=%0d reads=%0d want 1 1 3 2", ok, last_csb, n_wr - w0, n_rd - r0);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL len8_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_len6;
        logic [31:0] d; logic [2:0] b; logic l; bit ok, st, mv;
        start_xfer(24'h000000, 24'd6);
        get_word(0, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'hA3A2A1A0 || b !== 3'd4 || l !== 1'b0) begin
            errs++;
            $display("FAIL len6_w1: ok=%b data=%h bytes=%0d last=%b want A3A2A1A0 4 0", ok, d, b, l);
        end
        get_word(0, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'h0000A5A4 || b !== 3'd2 || l !== 1'b1) begin
            errs++;
            $display("FAIL len6_w2: ok=%b data=%h bytes=%0d last=%b want 0000A5A4 2 1", ok, d, b, l);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            errs++;
            $display("FAIL len6_done: got %b want 1", ok);
        end
    endtask

    task automatic test_len0;
        int w0, r0;
        w0 = n_wr; r0 = n_rd;
        start_xfer(24'h000040, 24'd0);
        vectors++;
        if (done !== 1'b1) begin
            errs++;
            $display("FAIL len0_done: got %b want 1", done);
        end
        repeat (5) @(negedge ifclk);
        vectors++;
        if (n_wr != w0 || n_rd != r0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL len0_quiet: writes=%0d reads=%0d busy=%b done=%b want 0 0 0 0", n_wr - w0, n_rd - r0, busy, done);
        end
    endtask

    task automatic test_stall;
        logic [31:0] d; logic [2:0] b; logic l; bit ok, st, mv;
        start_xfer(24'h000100, 24'd8);
        get_word(20, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'hA3A2A1A0 || b !== 3'd4 || l !== 1'b0) begin
            errs++;
            $display("FAIL stall_w1: ok=%b data=%h bytes=%0d last=%b want A3A2A1A0 4 0", ok, d, b, l);
        end
        vectors++;
        if (!st || mv) begin
            errs++;
            $display("FAIL stall_hold: stable=%b read_moved=%b want 1 0", st, mv);
        end
        get_word(0, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'hA7A6A5A4 || l !== 1'b1) begin
            errs++;
            $display("FAIL stall_w2: ok=%b data=%h last=%b want A7A6A5A4 1", ok, d, l);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            errs++;
            $display("FAIL stall_done: got %b want 1", ok);
        end
    endtask

    task automatic test_abort;
        logic [31:0] d; logic [2:0] b; logic l; bit ok, st, mv;
        int r0;
        r0 = n_rd;
        last_csb = 32'hFFFF_FFFF;
        start_xfer(24'h000010, 24'd16);
        get_word(0, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'hB3B2B1B0 || l !== 1'b0) begin
            errs++;
            $display("FAIL abort_w1: ok=%b data=%h last=%b want B3B2B1B0 0", ok, d, l);
        end
        abort = 1'b1;
        @(negedge ifclk);
        abort = 1'b0;
        get_word(0, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'hB7B6B5B4 || b !== 3'd4 || l !== 1'b1) begin
            errs++;
            $display("FAIL abort_w2: ok=%b data=%h bytes=%0d last=%b want B7B6B5B4 4 1", ok, d, b, l);
        end
        wait_done(ok);
        vectors++;
        if (!ok || last_csb !== 32'd1 || n_rd - r0 != 2) begin
            errs++;
            $display("FAIL abort_end: done=%b csb=%h reads=%0d want 1 1 2", ok, last_csb, n_rd - r0);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic [2:0] b; logic l; bit ok, st, mv;
        int t;
        start_xfer(24'h000000, 24'd8);
        t = 0;
        while (!bus.di_read_req && t < 100) begin
            @(negedge ifclk);
            t++;
        end
        vectors++;
        if (!bus.di_read_req) begin
            errs++;
            $display("FAIL rstmid_req: got 0 want 1");
        end
        @(negedge ifclk);
        #2 resetb = 1'b0;
        #1;
        vectors++;
        if ({busy, bus.di_read_mode, bus.di_write_mode, bus.out_valid} !== 4'd0 || bus.di_term_addr !== 16'd0 || bus.di_len !== 32'd0 || bus.out_data !== 32'd0) begin
            errs++;
            $display("FAIL rstmid_zero: ctl=%b term=%h len=%h data=%h want 0", {busy, bus.di_read_mode, bus.di_write_mode, bus.out_valid}, bus.di_term_addr, bus.di_len, bus.out_data);
        end
        repeat (2) @(negedge ifclk);
        resetb = 1'b1;
        @(negedge ifclk);
        start_xfer(24'h000020, 24'd4);
        get_word(0, d, b, l, ok, st, mv);
        vectors++;
        if (!ok || d !== 32'hC3C2C1C0 || b !== 3'd4 || l !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_rerun: ok=%b data=%h bytes=%0d last=%b want C3C2C1C0 4 1", ok, d, b, l);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            errs++;
            $display("FAIL rstmid_done: got %b want 1", ok);
        end
    endtask

    initial begin
        test_reset;
        test_len8;
        test_len6;
        test_len0;
        test_stall;
        test_abort;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/n25q_stream_reader.md
# n25q_stream_reader

Autonomous read sequencer that sits directly upstream of the N25Q SPI controller and masters its `di_*` terminal interface in place of the host. On `start`, it performs these steps:

- drops chip-select through the CTRL terminal;
- issues a READ command plus a 24-bit address through the DATA terminal;
- clocks `byte_len` bytes back as 32-bit words on a valid/ready stream;
- raises chip-select again.

It is intended for boot-time bitstream/config fetch, where a host-driven register loop is unavailable.

## Interface
Parameters:
- `CTRL_TERM`, 16'h0000: N25Q control terminal address.
- `DATA_TERM`, 16'h0001: N25Q data terminal address.
- `CSB_REG`, 32'd0: register address of the chip-select bit within `CTRL_TERM`.
- `READ_CMD`, 8'h03: flash opcode for a normal-speed read.

Ports:
- `ifclk`  in  1  clock.
- `resetb`  in  1  async active-low reset.
- `start`  in  1  one-cycle pulse, honoured only in IDLE.
- `abort`  in  1  terminate the current transfer at the next word boundary.
- `flash_addr`  in  24  start byte address, sampled on `start`.
- `byte_len`  in  24  bytes to read, sampled on `start`.
- `busy`  out  1  high from accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse on completion or abort.
- `out_data`  out  32  first flash byte in [7:0]; unused upper bytes are zero.
- `out_bytes`  out  3  valid bytes in `out_data`, 1..4.
- `out_valid` / `out_ready`  out / in  1  stream handshake.
- `out_last`  out  1  marks the final word.
- `di_term_addr`  out  16, `di_reg_addr`  out  32, `di_reg_datai`  out  32, `di_len`  out  32.
- `di_write_mode`, `di_write`, `di_read_mode`, `di_read_req`  out  1.
- `di_write_rdy`, `di_read_rdy`  in  1, `di_reg_datao`  in  32.

## Operation
States: IDLE, CS_LO, CMD, CMD_WAIT, GAP, RD, RD_WAIT, OUT, CS_HI, DONE.

- **IDLE:** all `di_*` outputs are 0.
  - `start` with `byte_len`=0 goes straight to DONE, with no flash access.
  - `start` with `byte_len`≠0 latches the address and length, sets `remain`=`byte_len`, and goes to CS_LO.
- **CS_LO:** drives `term=CTRL_TERM`, `reg_addr=CSB_REG`, `datai=0`, `write_mode=1`, `di_write=1` for one cycle, then goes to CMD.
- **CMD:** drives `term=DATA_TERM`, `write_mode=1`, `di_len=4`, `datai={addr[7:0],addr[15:8],addr[23:16],READ_CMD}`, and pulses `di_write` for one cycle.
- **CMD_WAIT:** ignores `di_write_rdy` in the first cycle after the pulse, then waits for `di_write_rdy`=1.
- **GAP:** holds both modes low for exactly one cycle, which resets the controller byte count. Then goes to RD.
- **RD:**
  - drives `read_mode=1`, `di_len={8'd0,byte_len}`, `datai=0`, and pulses `di_read_req` for one cycle;
  - `read_mode` stays high through every read word.
- **RD_WAIT:** skips the first cycle, then waits for `di_read_rdy`=1.
  - Latches `di_reg_datao` masked to `min(remain,4)` bytes.
  - Sets `out_bytes=min(remain,4)` and `out_last=(remain<=4)`.
  - Goes to OUT.
- **OUT:** holds `out_valid` until `out_ready`; on the transfer, `remain -= out_bytes`.
  - `remain`=0 or `abort` seen → CS_HI.
  - Otherwise → RD.
- **CS_HI:** performs a CTRL write with `datai=1` (one cycle), then goes to DONE.
- **DONE:** pulses `done`, then goes to IDLE.

Rules:
- `abort` is sticky until CS_HI.
  - It is acted on after the current handshake completes, so no flash transfer is truncated.
  - In CMD/RD it proceeds via the OUT/CS_HI path.
  - The word in flight is still delivered, with `out_last`=1.
- `start` is ignored while `busy`.
- `flash_addr + byte_len` beyond 2^24 wraps inside the flash; the block does not check it.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - `remain` 0.
- `busy` rises the cycle after `start`.
- First `di_write` (CTRL) occurs 1 cycle after `start`.
- Command-to-first-read overhead is CMD_WAIT + 1 GAP cycle.
- Each read word costs 1 request cycle, plus controller shift time, plus 1 capture cycle, plus stream stall cycles.
- `out_valid` must not drop without `out_ready`, and `out_data`, `out_bytes` and `out_last` must stay stable while stalled.
- Reset mid-transfer returns the block to IDLE immediately; csb in the controller is not restored, and the host must re-init.

## Test plan
- `start`, `addr=0x123456`, `len=8`: CTRL write of 0 → `datai=0x56341203`, `di_len=4` → two reads → words with `out_bytes=4`, `4`, `out_last` on the 2nd → CTRL write of 1 → `done`.
- `len=6` with flash bytes 0xA0..A5: second word `out_data=0x0000A5A4`, `out_bytes=2`, `out_last=1`.
- `len=0`: `done` 1 cycle after `start`, no `di_write` or `di_read_req` ever.
- `out_ready` held low for 20 cycles on word 1: no further `di_read_req`, and the data is stable throughout.
- `abort` during the 2nd of 4 words: 2nd word delivered with `out_last=1`, csb raised, `done`, no 3rd read.
- `resetb` asserted in RD_WAIT: all outputs 0 on the same edge; a new `start` afterwards runs normally.
